// File: rtl/recip_arbiter.sv
// Round-robin sequencer sharing one reciprocal lookup
// unit among NREQ neuron-side requesters.
module recip_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int DIV_LAT = 1,
  parameter  int LO_LIM  = 63,
  parameter  int HI_LIM  = 1250,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*11-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        resp_data,
  output logic              resp_sat,
  output logic [IW-1:0]     resp_id,
  output logic [10:0]       div_in,
  input  logic [7:0]        div_out,
  output logic              busy
);

  localparam int CW = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   prio_ptr;
  logic [CW-1:0]   wait_cnt;
  logic            last_done;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] id_hot;
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [10:0]     grant_op;
  logic [IW-1:0]   next_ptr;

  // pick the first eligible requester at or after prio_ptr
  always_comb begin
    int j;
    elig = req;
    if (last_done) elig[resp_id] = 1'b0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_op  = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(prio_ptr) + k) % NREQ;
      if (elig[j]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(j);
        grant_op  = req_data[11*j +: 11];
      end
    end
  end

  // one-hot of the served index and the next pointer
  always_comb begin
    id_hot = '0;
    id_hot[resp_id] = 1'b1;
    if (resp_id == IW'(NREQ - 1)) next_ptr = '0;
    else next_ptr = resp_id + 1'b1;
  end

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      wait_cnt  <= '0;
      last_done <= 1'b0;
      ack       <= '0;
      resp_data <= '0;
      resp_sat  <= 1'b0;
      resp_id   <= '0;
      div_in    <= '0;
      busy      <= 1'b0;
    end else begin
      ack       <= '0;
      last_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            resp_id <= grant_idx;
            div_in  <= grant_op;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          resp_sat <= (div_in < 11'(LO_LIM)) ||
                      (div_in > 11'(HI_LIM));
          wait_cnt <= CW'(DIV_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            resp_data <= div_out;
            ack       <= req & id_hot;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          prio_ptr  <= next_ptr;
          last_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
